// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with framing/parity error pulses
module uart_rx #(
    parameter int CLKS_PER_BIT = 1155
) (
    input  logic       osc_clk,
    input  logic       i_Rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Framing_Err,
    output logic       o_Parity_Err
);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d, byte_q, byte_d;
    logic        dv_q, dv_d, ferr_q, ferr_d, perr_q, perr_d;
    logic        active_q, active_d, par_bad_q, par_bad_d;

    // Next-state and output logic; samples the synchronised line mid-bit
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        data_d    = data_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        active_d  = active_q;
        par_bad_d = par_bad_q;
        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                idx_d     = '0;
                par_bad_d = 1'b0;
                active_d  = !rx_s_q;
                state_d   = rx_s_q ? IDLE : START;
            end
            START: begin
                if (cnt_q == HALF) begin
                    cnt_d    = '0;
                    active_d = !rx_s_q;
                    state_d  = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_s_q;
                    idx_d         = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (idx_q == 3'd7) state_d = PARITY;
`else
                    if (idx_q == 3'd7) state_d = STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s_q ^ (^data_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    dv_d    = rx_s_q && !par_bad_q;
                    ferr_d  = !rx_s_q;
                    perr_d  = par_bad_q;
                    byte_d  = (rx_s_q && !par_bad_q) ? data_q : byte_q;
                    state_d = CLEANUP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CLEANUP: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State registers and two-flop input synchroniser
    always_ff @(posedge osc_clk) begin
        if (i_Rst) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            active_q  <= 1'b0;
            par_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= i_Rx_Serial;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            active_q  <= active_d;
            par_bad_q <= par_bad_d;
        end
    end

    assign o_Rx_DV       = dv_q;
    assign o_Rx_Byte     = byte_q;
    assign o_Rx_Active   = active_q;
    assign o_Framing_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign o_Parity_Err  = perr_q;
`else
    assign o_Parity_Err  = 1'b0;
`endif
endmodule
